// File: rtl/accel_bar_display.sv
// Box-car averages signed X/Y/Z samples and drives a centre-split LED bar for one axis,
// chosen by switch or timed auto-scan. Optional peak-hold marker: define PEAK_HOLD_EN.
module accel_bar_display #(
  parameter int DATA_W    = 10,
  parameter int LED_N     = 8,
  parameter int AVG_LOG2  = 2,
  parameter int STEP      = 64,
  parameter int DWELL_CYC = 50_000_000,
  parameter int HOLD_CYC  = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] z_in,
  input  logic [1:0]               sel,
  output logic [LED_N-1:0]         led,
  output logic [2:0]               axis_ind,
  output logic                     avg_valid
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int HALF   = LED_N / 2;
  localparam int LVL_W  = $clog2(HALF + 1);
  localparam int DW_W   = $clog2(DWELL_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2**AVG_LOG2 - 1);

  typedef enum logic [1:0] {SCAN_X = 2'd0, SCAN_Y = 2'd1, SCAN_Z = 2'd2} scan_t;

  logic signed [DATA_W-1:0] in_arr [3];
  assign in_arr[0] = x_in;
  assign in_arr[1] = y_in;
  assign in_arr[2] = z_in;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             avg_valid_q, avg_valid_d;
  logic             last_smp;
  logic [3*DATA_W-1:0] avg_flat;

  assign last_smp = sample_valid && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d       = cnt_q;
    avg_valid_d = last_smp;
    if (sample_valid) cnt_d = last_smp ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_axis
      logic signed [ACC_W-1:0]  acc_q, acc_d, sum, shifted;
      logic signed [DATA_W-1:0] avg_q, avg_d;

      // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples, so no overflow.
      always_comb begin
        sum     = acc_q + ACC_W'(in_arr[gi]);
        shifted = sum >>> AVG_LOG2;
        acc_d   = acc_q;
        avg_d   = avg_q;
        if (sample_valid) begin
          if (last_smp) begin
            acc_d = '0;
            avg_d = shifted[DATA_W-1:0];
          end else begin
            acc_d = sum;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          acc_q <= '0;
          avg_q <= '0;
        end else begin
          acc_q <= acc_d;
          avg_q <= avg_d;
        end
      end

      assign avg_flat[gi*DATA_W +: DATA_W] = avg_q;
    end
  endgenerate

  scan_t            state_q, state_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (sel != 2'b11) begin
      state_d = SCAN_X;
      dwell_d = '0;
    end else if (dwell_q == DW_W'(DWELL_CYC - 1)) begin
      dwell_d = '0;
      case (state_q)
        SCAN_X:  state_d = SCAN_Y;
        SCAN_Y:  state_d = SCAN_Z;
        default: state_d = SCAN_X;
      endcase
    end else begin
      dwell_d = dwell_q + DW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SCAN_X;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  logic [1:0]               axis_idx;
  logic signed [DATA_W-1:0] avg_sel;
  logic [DATA_W:0]          mag;
  logic [31:0]              steps;
  logic [LVL_W-1:0]         lvl;
  logic                     cur_neg;
  logic [HALF-1:0]          pos_half, neg_half;
  logic [LED_N-1:0]         bar, led_q, led_d;
  logic [2:0]               axis_ind_q, axis_ind_d;

  always_comb begin
    axis_idx = (sel == 2'b11) ? state_q : sel;
    case (axis_idx)
      2'd1:    avg_sel = avg_flat[DATA_W +: DATA_W];
      2'd2:    avg_sel = avg_flat[2*DATA_W +: DATA_W];
      default: avg_sel = avg_flat[0 +: DATA_W];
    endcase
    cur_neg    = avg_sel[DATA_W-1];
    // One extra bit so the most negative sample has a representable magnitude.
    mag        = cur_neg ? -{avg_sel[DATA_W-1], avg_sel} : {avg_sel[DATA_W-1], avg_sel};
    steps      = (32'(mag) + STEP - 1) / STEP;
    lvl        = (steps > HALF) ? LVL_W'(HALF) : steps[LVL_W-1:0];
    axis_ind_d = 3'b001 << axis_idx;
  end

  generate
    for (gi = 0; gi < HALF; gi++) begin : g_bar
      assign pos_half[HALF-1-gi] = (LVL_W'(gi) < lvl);
      assign neg_half[gi]        = (LVL_W'(gi) < lvl);
    end
  endgenerate

  assign bar = cur_neg ? {neg_half, {HALF{1'b0}}} : {{HALF{1'b0}}, pos_half};

`ifdef PEAK_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int LED_IW = (LED_N > 2) ? $clog2(LED_N) : 1;

  logic [LVL_W-1:0]  peak_lvl_q, peak_lvl_d;
  logic              peak_neg_q, peak_neg_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [LED_N-1:0]  marker;
  logic [LED_IW-1:0] mk;

  always_comb begin
    peak_lvl_d = peak_lvl_q;
    peak_neg_d = peak_neg_q;
    hold_d     = hold_q + HOLD_W'(1);
    if (axis_ind_d != axis_ind_q) begin
      peak_lvl_d = '0;
      peak_neg_d = 1'b0;
      hold_d     = '0;
    end else if (lvl > peak_lvl_q || cur_neg != peak_neg_q ||
                 hold_q == HOLD_W'(HOLD_CYC - 1)) begin
      peak_lvl_d = lvl;
      peak_neg_d = cur_neg;
      hold_d     = '0;
    end
    mk     = peak_neg_d ? LED_IW'(HALF) + LED_IW'(peak_lvl_d) - LED_IW'(1)
                        : LED_IW'(HALF) - LED_IW'(peak_lvl_d);
    marker = '0;
    if (peak_lvl_d != '0) marker[mk] = 1'b1;
    led_d  = bar | marker;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_lvl_q <= '0;
      peak_neg_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      peak_lvl_q <= peak_lvl_d;
      peak_neg_q <= peak_neg_d;
      hold_q     <= hold_d;
    end
  end
`else
  assign led_d = bar;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q      <= '0;
      axis_ind_q <= 3'b001;
    end else begin
      led_q      <= led_d;
      axis_ind_q <= axis_ind_d;
    end
  end

  assign led       = led_q;
  assign axis_ind  = axis_ind_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: tb/tb_accel_bar_display.sv
// Directed-vector bench for accel_bar_display (DATA_W=10, LED_N=8, AVG_LOG2=2, STEP=64).
module tb_accel_bar_display;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic signed [9:0] x_in = '0, y_in = '0, z_in = '0;
  logic [1:0]        sel = 2'b00;
  logic [7:0]        led;
  logic [2:0]        axis_ind;
  logic              avg_valid;
  int                pass_cnt = 0;
  int                total_cnt = 0;

  always #5 clk = ~clk;

  accel_bar_display #(
    .DATA_W(10), .LED_N(8), .AVG_LOG2(2), .STEP(64), .DWELL_CYC(10), .HOLD_CYC(20)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .sel(sel),
    .led(led), .axis_ind(axis_ind), .avg_valid(avg_valid)
  );

  task automatic wait1();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int x, input int y, input int z);
    sample_valid = 1'b1;
    x_in = 10'(x);
    y_in = 10'(y);
    z_in = 10'(z);
    wait1();
    sample_valid = 1'b0;
  endtask

  task automatic block(input int x, input int y, input int z);
    for (int i = 0; i < 4; i++) strobe(x, y, z);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) wait1();
    total_cnt++;
    if (led !== 8'b0 || axis_ind !== 3'b001 || avg_valid !== 1'b0)
      $display("FAIL reset: led=%b axis=%b avg_valid=%b, want 00000000 001 0", led, axis_ind, avg_valid);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    wait1();
  endtask

  task automatic test_average();
    sel = 2'b00;
    for (int i = 0; i < 3; i++) strobe(100, 0, 0);
    total_cnt++;
    if (avg_valid !== 1'b0) $display("FAIL avg_early: avg_valid=%b want 0", avg_valid);
    else pass_cnt++;
    strobe(100, 0, 0);
    total_cnt++;
    if (avg_valid !== 1'b1 || led !== 8'b0)
      $display("FAIL avg_n1: avg_valid=%b led=%b want 1 00000000", avg_valid, led);
    else pass_cnt++;
    wait1();
    total_cnt++;
    if (avg_valid !== 1'b0 || led !== 8'b00001100)
      $display("FAIL avg_n2: avg_valid=%b led=%b want 0 00001100", avg_valid, led);
    else pass_cnt++;
    $display("avg x=100: led=%b", led);
  endtask

  task automatic test_negative();
    block(-512, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b11110000) $display("FAIL neg_sat: led=%b want 11110000", led);
    else pass_cnt++;
    block(-1, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b00010000) $display("FAIL neg_one: led=%b want 00010000", led);
    else pass_cnt++;
    strobe(1, 0, 0); strobe(0, 0, 0); strobe(0, 0, 0); strobe(0, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b00000000) $display("FAIL zero_avg: led=%b want 00000000", led);
    else pass_cnt++;
    // -1/4 must floor to -1, not truncate to 0
    strobe(-1, 0, 0); strobe(0, 0, 0); strobe(0, 0, 0); strobe(0, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b00010000) $display("FAIL floor: led=%b want 00010000", led);
    else pass_cnt++;
  endtask

  task automatic test_levels();
    int         vals [9];
    logic [7:0] exps [9];
    vals = '{64, 65, 128, 129, 192, 193, -64, -65, 511};
    exps = '{8'b00001000, 8'b00001100, 8'b00001100, 8'b00001110, 8'b00001110,
             8'b00001111, 8'b00010000, 8'b00110000, 8'b00001111};
    for (int i = 0; i < 9; i++) begin
      block(vals[i], 0, 0);
      wait1();
      total_cnt++;
      if (led !== exps[i]) $display("FAIL level_%0d: led=%b want %b", vals[i], led, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_axis_select();
    sel = 2'b00;
    block(200, -70, 0);
    wait1();
    sel = 2'b01;
    wait1();
    total_cnt++;
    if (led !== 8'b00110000 || axis_ind !== 3'b010)
      $display("FAIL sel_y: led=%b axis=%b want 00110000 010", led, axis_ind);
    else pass_cnt++;
    sel = 2'b10;
    wait1();
    total_cnt++;
    if (led !== 8'b00000000 || axis_ind !== 3'b100)
      $display("FAIL sel_z: led=%b axis=%b want 00000000 100", led, axis_ind);
    else pass_cnt++;
    sel = 2'b00;
    wait1();
    total_cnt++;
    if (led !== 8'b00001111 || axis_ind !== 3'b001)
      $display("FAIL sel_x: led=%b axis=%b want 00001111 001", led, axis_ind);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    sel = 2'b00;
    for (int i = 0; i < 3; i++) strobe(100, -200, 0);
    sel = 2'b01;
    strobe(100, -200, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b11110000 || axis_ind !== 3'b010)
      $display("FAIL simultaneous: led=%b axis=%b want 11110000 010", led, axis_ind);
    else pass_cnt++;
    sel = 2'b00;
  endtask

  task automatic test_autoscan();
    logic [10:0] exp;
    sel = 2'b00;
    block(200, -70, 0);
    wait1();
    sel = 2'b11;
    for (int k = 1; k <= 31; k++) begin
      wait1();
      if (k <= 10)      exp = {3'b001, 8'b00001111};
      else if (k <= 20) exp = {3'b010, 8'b00110000};
      else if (k <= 30) exp = {3'b100, 8'b00000000};
      else              exp = {3'b001, 8'b00001111};
      total_cnt++;
      if ({axis_ind, led} !== exp)
        $display("FAIL scan_cyc%0d: axis=%b led=%b want %b %b", k, axis_ind, led, exp[10:8], exp[7:0]);
      else pass_cnt++;
    end
    sel = 2'b00;
    wait1();
  endtask

  task automatic test_back_to_back();
    sel = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      strobe(i <= 4 ? 100 : -130, 0, 0);
      if (i == 4 || i == 8) begin
        total_cnt++;
        if (avg_valid !== 1'b1) $display("FAIL b2b_valid_%0d: avg_valid=%b want 1", i, avg_valid);
        else pass_cnt++;
      end else if (i == 5) begin
        total_cnt++;
        if (avg_valid !== 1'b0 || led !== 8'b00001100)
          $display("FAIL b2b_mid: avg_valid=%b led=%b want 0 00001100", avg_valid, led);
        else pass_cnt++;
      end
    end
    wait1();
    total_cnt++;
    if (led !== 8'b01110000) $display("FAIL b2b_second: led=%b want 01110000", led);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    sel = 2'b10;
    strobe(300, 0, 0);
    strobe(300, 0, 0);
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (led !== 8'b0 || axis_ind !== 3'b001 || avg_valid !== 1'b0)
      $display("FAIL reset_mid: led=%b axis=%b avg_valid=%b want 00000000 001 0", led, axis_ind, avg_valid);
    else pass_cnt++;
    sel = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    wait1();
    block(100, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b00001100) $display("FAIL reset_discard: led=%b want 00001100", led);
    else pass_cnt++;
  endtask

`ifdef PEAK_HOLD_EN
  task automatic test_peak_hold();
    int k;
    sel = 2'b00;
    block(200, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b00001111) $display("FAIL peak_first: led=%b want 00001111", led);
    else pass_cnt++;
    block(10, 0, 0);
    wait1();
    total_cnt++;
    if (led !== 8'b00001001) $display("FAIL peak_marker: led=%b want 00001001", led);
    else pass_cnt++;
    k = 0;
    while (led !== 8'b00001000 && k < 40) begin
      strobe(10, 0, 0);
      k++;
    end
    total_cnt++;
    if (k != 15) $display("FAIL peak_expire: cycles=%0d want 15", k);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
`ifdef PEAK_HOLD_EN
    test_peak_hold();
`else
    test_average();
    test_negative();
    test_levels();
    test_axis_select();
    test_simultaneous();
    test_autoscan();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
